// File: rtl/row_normalize_datapath_if.sv
`default_nettype none
// ============================================================================
//  Module      : row_normalize_datapath_if
//  Description : Handshake and matrix-RAM bus between the solve controller /
//                matrix RAM and the row-normalisation datapath.
//                  go_fetch_denominator / go_input_divider : controller requests
//                  current_row / lead_col                  : row and pivot column
//                  denominator_fetched / division_done     : level acknowledges
//                  div_by_zero                             : zero pivot flag
//                  mem_addr / mem_rd_en / mem_rdata        : RAM read port
//                  mem_wr_en / mem_wdata                   : RAM write port
//                Modport slave  = datapath side.
//                Modport master = controller / RAM side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface row_normalize_datapath_if #(
    parameter int DATA_W = 16,
    parameter int ROW_W  = 3,
    parameter int COL_W  = 3,
    parameter int ADDR_W = 6
) ();
    logic              go_fetch_denominator;
    logic              go_input_divider;
    logic [ROW_W-1:0]  current_row;
    logic [COL_W-1:0]  lead_col;
    logic              denominator_fetched;
    logic              division_done;
    logic              div_by_zero;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_wr_en;
    logic [DATA_W-1:0] mem_wdata;

    modport slave (
        input  go_fetch_denominator,
        input  go_input_divider,
        input  current_row,
        input  lead_col,
        output denominator_fetched,
        output division_done,
        output div_by_zero,
        output mem_addr,
        output mem_rd_en,
        input  mem_rdata,
        output mem_wr_en,
        output mem_wdata
    );

    modport master (
        output go_fetch_denominator,
        output go_input_divider,
        output current_row,
        output lead_col,
        input  denominator_fetched,
        input  division_done,
        input  div_by_zero,
        input  mem_addr,
        input  mem_rd_en,
        output mem_rdata,
        input  mem_wr_en,
        input  mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/row_normalize_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : row_normalize_datapath
//  Description : Row normalisation for the linear-system solver. Fetches the
//                pivot entry of a row as the denominator, then divides every
//                entry from lead_col to the last column by it (signed fixed
//                point, truncating toward zero, saturating) and writes each
//                quotient back in place.
//  Ports       : clk            - system clock
//                program_reset  - asynchronous active-high reset
//                bus (slave)    - controller handshake + matrix RAM port
//  Revision    : 1.0 - initial release
// ============================================================================
module row_normalize_datapath #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int COLS   = 5,
    parameter int ROW_W  = 3,
    parameter int COL_W  = 3,
    parameter int ADDR_W = 6
) (
    input  logic                     clk,
    input  logic                     program_reset,
    row_normalize_datapath_if.slave  bus
);

    // Dividend width: |num| << FRAC_W. One quotient bit per cycle.
    localparam int QW      = DATA_W + FRAC_W;
    localparam int DIV_LEN = QW;
    localparam int CNT_W   = $clog2(DIV_LEN + 1);

    localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(DIV_LEN - 1);
    localparam logic [COL_W-1:0]  C_COL_LAST = COL_W'(COLS - 1);
    localparam logic [COL_W:0]    C_COLS     = (COL_W + 1)'(COLS);
    localparam logic [QW-1:0]     C_POS_LIM  = QW'((64'd1 << (DATA_W - 1)) - 64'd1);
    localparam logic [QW-1:0]     C_NEG_LIM  = QW'(64'd1 << (DATA_W - 1));
    localparam logic [DATA_W-1:0] C_SAT_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] C_SAT_MIN  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] C_UNITY    = DATA_W'(64'd1 << FRAC_W);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_F_RD   = 4'd1;
    localparam logic [3:0] S_F_WAIT = 4'd2;
    localparam logic [3:0] S_F_HOLD = 4'd3;
    localparam logic [3:0] S_C_RD   = 4'd4;
    localparam logic [3:0] S_C_WAIT = 4'd5;
    localparam logic [3:0] S_C_DIV  = 4'd6;
    localparam logic [3:0] S_C_WR   = 4'd7;
    localparam logic [3:0] S_D_HOLD = 4'd8;

    logic [3:0]        state_q,  state_d;
    logic [COL_W-1:0]  col_q,    col_d;
    logic [DATA_W-1:0] denom_q,  denom_d;
    logic              dbz_q,    dbz_d;
    logic [QW-1:0]     dvd_q,    dvd_d;     // dividend shifts out, quotient shifts in
    logic [DATA_W-1:0] rem_q,    rem_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic              neg_q,    neg_d;
    logic              piv_q,    piv_d;     // current column is the pivot column

    logic [ADDR_W-1:0] w_row_base;
    logic [ADDR_W-1:0] w_fetch_addr;
    logic [ADDR_W-1:0] w_col_addr;
    logic              w_col_oob;
    logic              w_skip_row;
    logic [DATA_W-1:0] w_den_mag;
    logic [DATA_W-1:0] w_num_mag;
    logic [DATA_W:0]   w_trial;
    logic [DATA_W:0]   w_den_ext;
    logic [DATA_W:0]   w_diff;
    logic              w_ge;
    logic [DATA_W-1:0] w_result;

    // ------------------------------------------------------------------
    // Address generation and column bounds
    // ------------------------------------------------------------------
    assign w_row_base   = ADDR_W'(bus.current_row) * ADDR_W'(COLS);
    assign w_fetch_addr = w_row_base + ADDR_W'(bus.lead_col);
    assign w_col_addr   = w_row_base + ADDR_W'(col_q);
    assign w_col_oob    = ({1'b0, col_q} >= C_COLS);
    // A zero pivot or an out-of-range lead column yields an empty row.
    assign w_skip_row   = dbz_q | w_col_oob;

    // ------------------------------------------------------------------
    // Restoring divider step on magnitudes
    // ------------------------------------------------------------------
    assign w_den_mag = denom_q[DATA_W-1] ? -denom_q : denom_q;
    assign w_num_mag = bus.mem_rdata[DATA_W-1] ? -bus.mem_rdata : bus.mem_rdata;
    assign w_trial   = {rem_q, dvd_q[QW-1]};
    assign w_den_ext = {1'b0, w_den_mag};
    assign w_ge      = (w_trial >= w_den_ext);
    assign w_diff    = w_trial - w_den_ext;

    // Sign restore and saturation of the finished quotient held in dvd_q.
    always_comb begin
        w_result = dvd_q[DATA_W-1:0];
        if (piv_q) begin
            w_result = C_UNITY;
        end else if (!neg_q) begin
            w_result = (dvd_q > C_POS_LIM) ? C_SAT_MAX : dvd_q[DATA_W-1:0];
        end else begin
            w_result = (dvd_q > C_NEG_LIM) ? C_SAT_MIN : -dvd_q[DATA_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge program_reset) begin
        if (program_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.go_fetch_denominator) begin
                    state_d = S_F_RD;
                end else if (bus.go_input_divider) begin
                    state_d = S_C_RD;
                end
            end
            S_F_RD:   state_d = S_F_WAIT;
            S_F_WAIT: state_d = S_F_HOLD;
            S_F_HOLD: begin
                if (!bus.go_fetch_denominator) begin
                    state_d = S_IDLE;
                end
            end
            S_C_RD:   state_d = w_skip_row ? S_D_HOLD : S_C_WAIT;
            S_C_WAIT: state_d = S_C_DIV;
            S_C_DIV: begin
                if (cnt_q == C_CNT_LAST) begin
                    state_d = S_C_WR;
                end
            end
            S_C_WR:   state_d = (col_q == C_COL_LAST) ? S_D_HOLD : S_C_RD;
            S_D_HOLD: begin
                if (!bus.go_input_divider) begin
                    state_d = S_IDLE;
                end
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.denominator_fetched = 1'b0;
        bus.division_done       = 1'b0;
        bus.mem_addr            = '0;
        bus.mem_rd_en           = 1'b0;
        bus.mem_wr_en           = 1'b0;
        bus.mem_wdata           = '0;
        case (state_q)
            S_F_RD: begin
                bus.mem_rd_en = 1'b1;
                bus.mem_addr  = w_fetch_addr;
            end
            S_F_HOLD: bus.denominator_fetched = 1'b1;
            S_C_RD: begin
                if (!w_skip_row) begin
                    bus.mem_rd_en = 1'b1;
                    bus.mem_addr  = w_col_addr;
                end
            end
            S_C_WR: begin
                bus.mem_wr_en = 1'b1;
                bus.mem_addr  = w_col_addr;
                bus.mem_wdata = w_result;
            end
            S_D_HOLD: bus.division_done = 1'b1;
            default: ;
        endcase
    end

    assign bus.div_by_zero = dbz_q;

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        col_d   = col_q;
        denom_d = denom_q;
        dbz_d   = dbz_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        piv_d   = piv_q;
        case (state_q)
            S_IDLE: begin
                if (!bus.go_fetch_denominator && bus.go_input_divider) begin
                    col_d = bus.lead_col;
                end
            end
            S_F_WAIT: begin
                denom_d = bus.mem_rdata;
                dbz_d   = (bus.mem_rdata == '0);
            end
            S_C_WAIT: begin
                dvd_d = {w_num_mag, {FRAC_W{1'b0}}};
                rem_d = '0;
                cnt_d = '0;
                neg_d = bus.mem_rdata[DATA_W-1] ^ denom_q[DATA_W-1];
                piv_d = (col_q == bus.lead_col);
            end
            S_C_DIV: begin
                rem_d = w_ge ? w_diff[DATA_W-1:0] : w_trial[DATA_W-1:0];
                dvd_d = {dvd_q[QW-2:0], w_ge};
                cnt_d = cnt_q + CNT_W'(1);
            end
            S_C_WR: begin
                if (col_q != C_COL_LAST) begin
                    col_d = col_q + COL_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge program_reset) begin
        if (program_reset) begin
            col_q   <= '0;
            denom_q <= '0;
            dbz_q   <= 1'b0;
            dvd_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            piv_q   <= 1'b0;
        end else begin
            col_q   <= col_d;
            denom_q <= denom_d;
            dbz_q   <= dbz_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            piv_q   <= piv_d;
        end
    end

endmodule
`default_nettype wire
